// File: rtl/qkv_proj_sequencer.sv
// QKV projection sequencer: per input-channel group it loads DEPTH weight rows,
// feeds every token, drains the array, and streams partial-sum SRAM read/write addresses.
module qkv_proj_sequencer #(
  parameter int SPATIAL = 27,
  parameter int CHANNEL = 64,
  parameter int DEPTH   = 4,
  parameter int DRAIN   = 19,
  parameter int OUT_LAT = 18,
  parameter int ADDR_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              is_wt_o,
  output logic              is_read_o,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic              acc_rd_en_o,
  output logic [ADDR_W-1:0] acc_rd_addr_o,
  output logic              acc_wr_en_o,
  output logic [ADDR_W-1:0] acc_wr_addr_o,
  output logic              acc_first_o
);

  localparam int TOKENS = SPATIAL * SPATIAL;
  localparam int GROUPS = CHANNEL / DEPTH;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int K_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int T_W    = (TOKENS > 1) ? $clog2(TOKENS) : 1;
  localparam int D_W    = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam int LAT_W  = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;
  localparam int LAT_M1 = (OUT_LAT > 0) ? OUT_LAT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [D_W-1:0]    d_q, d_d;

  logic              waitRun_q, waitRun_d;
  logic [LAT_W-1:0]  waitCnt_q, waitCnt_d;
  logic              accEn_q, accEn_d;
  logic [T_W-1:0]    accIdx_q, accIdx_d;
  logic              accFirst_q, accFirst_d;
  logic              wrEn_q;
  logic [T_W-1:0]    wrIdx_q;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              isWt_q, isWt_d;
  logic              isRead_q, isRead_d;
  logic [ADDR_W-1:0] src_q, src_d;

  logic [31:0]       wRow, pRow;
  logic              feedStart, winStart;

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    k_d     = k_q;
    t_d     = t_q;
    d_d     = d_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WLOAD;
          grp_d   = '0;
          k_d     = '0;
        end
      end
      S_WLOAD: begin
        if (k_q == K_W'(DEPTH - 1)) begin
          state_d = S_FEED;
          k_d     = '0;
          t_d     = '0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_FEED: begin
        if (t_q == T_W'(TOKENS - 1)) begin
          state_d = S_DRAIN;
          t_d     = '0;
          d_d     = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      S_DRAIN: begin
        if (d_q == D_W'(DRAIN - 1)) begin
          d_d = '0;
          if (grp_q == GRP_W'(GROUPS - 1)) begin
            state_d = S_DONE;
          end else begin
            grp_d   = grp_q + GRP_W'(1);
            k_d     = '0;
            state_d = S_WLOAD;
          end
        end else begin
          d_d = d_q + D_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output port is a flop.
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    isWt_d   = 1'b0;
    isRead_d = 1'b0;
    src_d    = '0;
    wRow     = 32'(grp_d) * 32'(DEPTH) + 32'(k_d);
    pRow     = 32'(grp_d) * 32'(TOKENS) + 32'(t_d);
    unique case (state_d)
      S_WLOAD: begin
        busy_d   = 1'b1;
        isWt_d   = 1'b1;
        isRead_d = 1'b1;
        src_d    = ADDR_W'(wRow);
      end
      S_FEED: begin
        busy_d   = 1'b1;
        isRead_d = 1'b1;
        src_d    = ADDR_W'(pRow);
      end
      S_DRAIN: busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // The accumulator window is timed from the first feed cycle of each group,
  // independent of the main FSM, so it can spill over into the drain phase.
  always_comb begin
    feedStart  = (state_d == S_FEED) && (state_q != S_FEED);
    winStart   = (OUT_LAT == 0) ? feedStart
                                : (waitRun_q && (waitCnt_q == LAT_W'(LAT_M1)));
    waitRun_d  = waitRun_q;
    waitCnt_d  = waitCnt_q;
    accEn_d    = accEn_q;
    accIdx_d   = accIdx_q;
    accFirst_d = accFirst_q;
    if (feedStart) begin
      waitRun_d = (OUT_LAT != 0);
      waitCnt_d = '0;
    end else if (winStart) begin
      waitRun_d = 1'b0;
      waitCnt_d = '0;
    end else if (waitRun_q) begin
      waitCnt_d = waitCnt_q + LAT_W'(1);
    end
    if (winStart) begin
      accEn_d    = 1'b1;
      accIdx_d   = '0;
      accFirst_d = (grp_d == '0);
    end else if (accEn_q) begin
      if (accIdx_q == T_W'(TOKENS - 1)) begin
        accEn_d    = 1'b0;
        accIdx_d   = '0;
        accFirst_d = 1'b0;
      end else begin
        accIdx_d = accIdx_q + T_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      grp_q      <= '0;
      k_q        <= '0;
      t_q        <= '0;
      d_q        <= '0;
      waitRun_q  <= 1'b0;
      waitCnt_q  <= '0;
      accEn_q    <= 1'b0;
      accIdx_q   <= '0;
      accFirst_q <= 1'b0;
      wrEn_q     <= 1'b0;
      wrIdx_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      isWt_q     <= 1'b0;
      isRead_q   <= 1'b0;
      src_q      <= '0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      k_q        <= k_d;
      t_q        <= t_d;
      d_q        <= d_d;
      waitRun_q  <= waitRun_d;
      waitCnt_q  <= waitCnt_d;
      accEn_q    <= accEn_d;
      accIdx_q   <= accIdx_d;
      accFirst_q <= accFirst_d;
      wrEn_q     <= accEn_q;
      wrIdx_q    <= accIdx_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      isWt_q     <= isWt_d;
      isRead_q   <= isRead_d;
      src_q      <= src_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign is_wt_o       = isWt_q;
  assign is_read_o     = isRead_q;
  assign src_addr_o    = src_q;
  assign acc_rd_en_o   = accEn_q;
  assign acc_rd_addr_o = ADDR_W'(accIdx_q);
  assign acc_wr_en_o   = wrEn_q;
  assign acc_wr_addr_o = ADDR_W'(wrIdx_q);
  assign acc_first_o   = accFirst_q;

endmodule

// File: doc/qkv_proj_sequencer.md
# qkv_proj_sequencer

Cycle-accurate controller for the QKV projection pass of the MHA encoder block. It drives the 16-block PE array one input-channel group at a time. Each group gets DEPTH weight-load cycles, then SPATIAL² token-feed cycles, then a drain window. Alongside that it generates the read-modify-write address stream for the 3×16-lane partial-sum SRAM that accumulates the group results.

## Interface
- SPATIAL, 27, token grid side; TOKENS = SPATIAL*SPATIAL
- CHANNEL, 64, input channels; GROUPS = CHANNEL/DEPTH (must divide exactly)
- DEPTH, 4, systolic depth = weight rows loaded per group
- DRAIN, 19, idle cycles after the last token of a group (activation propagation)
- OUT_LAT, 18, cycles from first feed cycle to first valid PE output; must satisfy OUT_LAT ≤ DRAIN-1
- ADDR_W, 16, width of all address outputs
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state and outputs to reset values
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last group's drain completes
- is_wt  out  1  PE array in weight-load mode; weight SRAM selected
- is_read  out  1  source SRAM read enable
- src_addr  out  ADDR_W  weight row (when is_wt) or patch row (otherwise)
- acc_rd_en  out  1  partial-sum SRAM read enable
- acc_rd_addr  out  ADDR_W  token index being read
- acc_wr_en  out  1  partial-sum SRAM write enable
- acc_wr_addr  out  ADDR_W  token index being written
- acc_first  out  1  aligned with acc_rd_en; group 0, so the accumulator adds zero instead of SRAM data

## Operation
- States: IDLE, WLOAD, FEED, DRAIN, DONE. Counters: grp (0..GROUPS-1), k (0..DEPTH-1), t (0..TOKENS-1), d (0..DRAIN-1), plus an independent acc counter.
- IDLE: all outputs 0. When start=1: grp←0, enter WLOAD.
- WLOAD: is_wt=1, is_read=1, src_addr = grp*DEPTH + k. Exit to FEED after k = DEPTH-1.
- FEED: is_wt=0, is_read=1, src_addr = grp*TOKENS + t. Exit to DRAIN after t = TOKENS-1.
- DRAIN: is_read=0, is_wt=0. After d = DRAIN-1:
  - if grp = GROUPS-1, go to DONE;
  - otherwise grp←grp+1 and go to WLOAD.
- DONE: done=1 for one cycle, busy=0, then IDLE. start is ignored in DONE and in all busy states.
- Accumulator window (per group):
  - acc_rd_en is high for exactly TOKENS consecutive cycles.
  - The window starts OUT_LAT cycles after the first FEED cycle of that group.
  - acc_rd_addr runs 0..TOKENS-1.
  - acc_first = (grp = 0) throughout the window.
- acc_wr_en and acc_wr_addr are acc_rd_en and acc_rd_addr delayed by exactly one cycle.
- The OUT_LAT constraint guarantees the last write lands inside DRAIN, so windows of consecutive groups never overlap.
- All outputs are registered. Addresses are zero-extended/truncated to ADDR_W. They are 0 whenever their enable is 0.

## Timing
- Reset value of every output is 0. Reset mid-pass aborts immediately: no done pulse. After release the block sits in IDLE.
- Cycle numbering: start is high at edge 0. First WLOAD cycle is cycle 1; busy rises in cycle 1.
- Group g occupies DEPTH+TOKENS+DRAIN cycles, starting at cycle 1 + g*(DEPTH+TOKENS+DRAIN).
- done is high in cycle 1 + GROUPS*(DEPTH+TOKENS+DRAIN). Default: 1 + 16*752 = 12033.
- Back-to-back: start may be asserted in the cycle after done (IDLE). A start coincident with done is dropped.
- No data-dependent stalls; the schedule is fixed by parameters.

## Test plan
- Defaults; start at cycle 0:
  - busy rises at cycle 1; is_wt high cycles 1–4 with src_addr 0,1,2,3.
  - FEED cycles 5–733 with src_addr 0..728.
  - done exactly at cycle 12033; busy low the same cycle.
- SPATIAL=3, CHANNEL=8, DRAIN=5, OUT_LAT=3 (18 cycles per group):
  - group 1 WLOAD src_addr 4..7 at cycles 19–22; FEED src_addr 9..17.
  - done at cycle 37.
- Same small config, accumulator window:
  - group 0 acc_rd_en cycles 8–16 with addr 0..8 and acc_first=1.
  - acc_wr_en cycles 9–17.
  - group 1 window cycles 26–34 with acc_first=0.
  - never acc_rd_en during any WLOAD cycle.
- start pulsed during FEED and again during DONE → no effect on counters; done count stays 1.
- reset driven low mid-FEED of group 1 → all outputs 0 asynchronously (same cycle); no done. After release plus start, the full pass restarts from grp 0 with nominal timing.
- Two passes, start in cycle after first done → second done exactly 1 + GROUPS*(DEPTH+TOKENS+DRAIN) cycles after the second start edge.
